// File: rtl/gpr_port_arbiter.sv
// gpr_port_arbiter
//   Owns the single write port and bank-select lines of the 4-bank GPR file.
//   Two write requesters (writeback "wb" and load/trap return "ld") share the
//   port under round-robin arbitration. Bank switches are sequenced so that a
//   switch never lands in the same cycle as a write, and a pending switch can
//   only be deferred by STARVE_MAX granted writes before it takes priority.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   wb_valid/addr/data/ready  writeback write request and its acceptance
//   ld_valid/addr/data/ready  load/trap write request and its acceptance
//   sw_req, sw_bank, sw_ack   bank-switch request, target bank, applied pulse
//   rf_d_in, rf_addr          registered write data/address to the register file
//   rf_file_sel, cur_bank     registered active bank (always equal)
//   rf_rw                     registered 1 = read, 0 = write
module gpr_port_arbiter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              sw_req,
   input  logic [1:0]        sw_bank,
   output logic              sw_ack,
   output logic [DATA_W-1:0] rf_d_in,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [1:0]        rf_file_sel,
   output logic              rf_rw,
   output logic [1:0]        cur_bank
);

   localparam int unsigned StarveW = 4;

   typedef enum logic [1:0] {StIdle, StPend, StSwitch} state_e;

   state_e              state_q;
   logic                rr_ld_q;     // 1: ld wins the next tie
   logic [StarveW-1:0]  starve_q;
   logic [1:0]          bank_q;
   logic                sw_ack_q;
   logic                rf_rw_q;
   logic [ADDR_W-1:0]   rf_addr_q;
   logic [DATA_W-1:0]   rf_d_q;

   logic switch_now;
   logic new_req;
   logic any_valid;
   logic grant_wb;
   logic grant_ld;

   always_comb begin
      // A starved pending switch is applied directly from PEND, so that cycle
      // acts as the switch cycle itself.
      switch_now = (state_q == StSwitch) ||
                   ((state_q == StPend) && (starve_q == StarveW'(STARVE_MAX)));
      // sw_req is still high in the ack cycle; it only counts as new afterwards.
      new_req    = sw_req && !sw_ack_q;
      any_valid  = wb_valid || ld_valid;
      grant_wb   = 1'b0;
      grant_ld   = 1'b0;
      if (!rst && !switch_now) begin
         if (wb_valid && ld_valid) begin
            grant_ld = rr_ld_q;
            grant_wb = !rr_ld_q;
         end else begin
            grant_wb = wb_valid;
            grant_ld = ld_valid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         rr_ld_q   <= 1'b0;
         starve_q  <= '0;
         bank_q    <= 2'd0;
         sw_ack_q  <= 1'b0;
         rf_rw_q   <= 1'b1;
         rf_addr_q <= '0;
         rf_d_q    <= '0;
      end else begin
         sw_ack_q <= 1'b0;
         rf_rw_q  <= 1'b1;
         if (grant_wb) begin
            rf_rw_q   <= 1'b0;
            rf_addr_q <= wb_addr;
            rf_d_q    <= wb_data;
            rr_ld_q   <= 1'b1;
         end else if (grant_ld) begin
            rf_rw_q   <= 1'b0;
            rf_addr_q <= ld_addr;
            rf_d_q    <= ld_data;
            rr_ld_q   <= 1'b0;
         end

         if (switch_now) begin
            // No grant this cycle, so the bank change cannot meet a write.
            bank_q   <= sw_bank;
            sw_ack_q <= 1'b1;
            starve_q <= '0;
            state_q  <= StIdle;
         end else begin
            case (state_q)
               StIdle: begin
                  if (new_req) begin
                     if (any_valid) begin
                        state_q  <= StPend;
                        starve_q <= StarveW'(1);
                     end else begin
                        state_q <= StSwitch;
                     end
                  end
               end
               StPend: begin
                  if (!any_valid) begin
                     state_q <= StSwitch;
                  end else begin
                     starve_q <= starve_q + StarveW'(1);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign wb_ready    = grant_wb;
   assign ld_ready    = grant_ld;
   assign sw_ack      = sw_ack_q;
   assign rf_d_in     = rf_d_q;
   assign rf_addr     = rf_addr_q;
   assign rf_rw       = rf_rw_q;
   assign rf_file_sel = bank_q;
   assign cur_bank    = bank_q;

endmodule

// File: tb/tb_gpr_port_arbiter.sv
module tb_gpr_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_valid, ld_valid, sw_req;
   logic [AW-1:0] wb_addr, ld_addr;
   logic [DW-1:0] wb_data, ld_data;
   logic [1:0]    sw_bank;
   logic          wb_ready, ld_ready, sw_ack, rf_rw;
   logic [DW-1:0] rf_d_in;
   logic [AW-1:0] rf_addr;
   logic [1:0]    rf_file_sel, cur_bank;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   gpr_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
      .sw_req(sw_req), .sw_bank(sw_bank), .sw_ack(sw_ack),
      .rf_d_in(rf_d_in), .rf_addr(rf_addr), .rf_file_sel(rf_file_sel),
      .rf_rw(rf_rw), .cur_bank(cur_bank)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs after each edge, from the arbitration rules.
   bit            m_on = 1'b0;
   logic          m_rw, m_ack;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [1:0]    m_bank;
   int            m_last;       // requester granted most recently: 0 wb, 1 ld
   bit            m_pending;    // switch requested, waiting for a write-free cycle
   int            m_defer;      // writes that have deferred the pending switch
   bit            m_switching;  // the next cycle is the dedicated switch cycle

   always @(negedge clk) begin
      bit blocked, g_wb, g_ld, any, prev_ack;
      if (m_on) begin
         chk("rf_rw", 32'(rf_rw), 32'(m_rw));
         chk("rf_addr", 32'(rf_addr), 32'(m_addr));
         chk("rf_d_in", rf_d_in, m_data);
         chk("rf_file_sel", 32'(rf_file_sel), 32'(m_bank));
         chk("cur_bank", 32'(cur_bank), 32'(m_bank));
         chk("sw_ack", 32'(sw_ack), 32'(m_ack));
      end
      blocked = m_switching || (m_pending && m_defer == SM);
      g_wb = 1'b0;
      g_ld = 1'b0;
      if (!rst && !blocked) begin
         if (wb_valid && ld_valid) begin
            if (m_last == 1) g_wb = 1'b1;
            else g_ld = 1'b1;
         end else begin
            g_wb = wb_valid;
            g_ld = ld_valid;
         end
      end
      if (m_on) begin
         chk("wb_ready", 32'(wb_ready), 32'(g_wb));
         chk("ld_ready", 32'(ld_ready), 32'(g_ld));
      end
      if (rst) begin
         m_on = 1'b1;
         m_rw = 1'b1; m_ack = 1'b0; m_addr = '0; m_data = '0; m_bank = 2'd0;
         m_last = 1;  // wb wins the first tie after reset
         m_pending = 1'b0; m_defer = 0; m_switching = 1'b0;
      end else begin
         any = wb_valid || ld_valid;
         prev_ack = m_ack;
         m_ack = 1'b0;
         if (g_wb) begin
            m_rw = 1'b0; m_addr = wb_addr; m_data = wb_data; m_last = 0;
         end else if (g_ld) begin
            m_rw = 1'b0; m_addr = ld_addr; m_data = ld_data; m_last = 1;
         end else begin
            m_rw = 1'b1;
         end
         if (blocked) begin
            m_bank = sw_bank; m_ack = 1'b1;
            m_pending = 1'b0; m_switching = 1'b0; m_defer = 0;
         end else if (m_pending) begin
            if (!any) begin
               m_pending = 1'b0; m_switching = 1'b1;
            end else begin
               m_defer++;
            end
         end else if (sw_req && !prev_ack) begin
            if (any) begin
               m_pending = 1'b1; m_defer = 1;
            end else begin
               m_switching = 1'b1;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      wb_valid = 1'b0; ld_valid = 1'b0; sw_req = 1'b0; sw_bank = 2'd0;
      wb_addr = '0; ld_addr = '0; wb_data = '0; ld_data = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [AW-1:0] wr_q[$];
   int            acks;
   logic          e_wb [7] = '{1, 0, 1, 0, 0, 1, 0};
   logic          e_ld [7] = '{0, 1, 0, 1, 0, 0, 1};
   logic          e_rw [7] = '{1, 0, 0, 0, 0, 1, 0};
   logic          e_ak [7] = '{0, 0, 0, 0, 0, 1, 0};
   logic [1:0]    e_bk [7] = '{0, 0, 0, 0, 0, 3, 3};
   logic [AW-1:0] c_addr [4] = '{1, 2, 1, 2};

   initial begin
      idle_inputs();
      rst = 1'b1;
      wb_valid = 1'b1;  // readys must stay low while in reset
      tick();
      @(negedge clk);
      chk("rst_rf_rw", 32'(rf_rw), 32'd1);
      chk("rst_wb_ready", 32'(wb_ready), 32'd0);
      chk("rst_cur_bank", 32'(cur_bank), 32'd0);
      chk("rst_rf_d_in", rf_d_in, 32'd0);
      tick();
      rst = 1'b0;
      wb_valid = 1'b0;

      // Single write
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_wb_ready", 32'(wb_ready), 32'd1);
      chk("t1_ld_ready", 32'(ld_ready), 32'd0);
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      chk("t1_rf_rw", 32'(rf_rw), 32'd0);
      chk("t1_rf_addr", 32'(rf_addr), 32'd5);
      chk("t1_rf_d_in", rf_d_in, 32'hDEADBEEF);
      chk("t1_rf_file_sel", 32'(rf_file_sel), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_rf_rw_after", 32'(rf_rw), 32'd1);
      chk("t1_rf_addr_hold", 32'(rf_addr), 32'd5);

      // Contention: wb, ld, wb, ld
      do_reset();
      wb_valid = 1'b1; ld_valid = 1'b1;
      wb_addr = 5'd1; ld_addr = 5'd2; wb_data = 32'h11; ld_data = 32'h22;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i < 4) chk("t2_wb_ready", 32'(wb_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i >= 1 && i <= 4) begin
            chk("t2_rf_rw", 32'(rf_rw), 32'd0);
            chk("t2_rf_addr", 32'(rf_addr), 32'(c_addr[i-1]));
         end
         if (i == 5) chk("t2_rf_rw_end", 32'(rf_rw), 32'd1);
         tick();
         if (i == 3) begin
            wb_valid = 1'b0; ld_valid = 1'b0;
         end
      end

      // Idle switch to bank 2
      do_reset();
      sw_req = 1'b1; sw_bank = 2'd2;
      @(negedge clk);
      chk("t3_ack_c0", 32'(sw_ack), 32'd0);
      tick();
      @(negedge clk);
      chk("t3_ack_c1", 32'(sw_ack), 32'd0);
      chk("t3_bank_c1", 32'(cur_bank), 32'd0);
      tick();
      @(negedge clk);
      chk("t3_ack_c2", 32'(sw_ack), 32'd1);
      chk("t3_bank_c2", 32'(cur_bank), 32'd2);
      tick();
      sw_req = 1'b0;
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
      @(negedge clk);
      chk("t3_ack_c3", 32'(sw_ack), 32'd0);
      chk("t3_wb_ready", 32'(wb_ready), 32'd1);
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      chk("t3_rf_rw", 32'(rf_rw), 32'd0);
      chk("t3_rf_addr", 32'(rf_addr), 32'd7);
      chk("t3_rf_file_sel", 32'(rf_file_sel), 32'd2);
      tick();

      // Starvation: 4 grants, one blocked cycle, ack, RR resumes
      do_reset();
      wb_valid = 1'b1; ld_valid = 1'b1;
      wb_addr = 5'd3; ld_addr = 5'd4; wb_data = 32'h33; ld_data = 32'h44;
      sw_req = 1'b1; sw_bank = 2'd3;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("t4_wb_ready", 32'(wb_ready), 32'(e_wb[i]));
         chk("t4_ld_ready", 32'(ld_ready), 32'(e_ld[i]));
         chk("t4_rf_rw", 32'(rf_rw), 32'(e_rw[i]));
         chk("t4_sw_ack", 32'(sw_ack), 32'(e_ak[i]));
         chk("t4_rf_file_sel", 32'(rf_file_sel), 32'(e_bk[i]));
         tick();
         if (i == 5) sw_req = 1'b0;
      end
      idle_inputs();

      // Reset while a switch to bank 1 is pending
      do_reset();
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hAA; sw_req = 1'b1; sw_bank = 2'd1;
      @(negedge clk);
      chk("t5_wb_ready", 32'(wb_ready), 32'd1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t5_ready_in_rst", 32'(wb_ready), 32'd0);
      tick();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("t5_rf_rw", 32'(rf_rw), 32'd1);
      chk("t5_rf_addr", 32'(rf_addr), 32'd0);
      chk("t5_rf_d_in", rf_d_in, 32'd0);
      chk("t5_cur_bank", 32'(cur_bank), 32'd0);
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (sw_ack === 1'b1) acks++;
         tick();
      end
      chk("t5_no_ack", 32'(acks), 32'd0);
      chk("t5_bank_end", 32'(cur_bank), 32'd0);

      // Same-bank switch overlapping three writes
      do_reset();
      sw_req = 1'b1; sw_bank = 2'd0;
      acks = 0;
      wr_q.delete();
      for (int c = 0; c < 10; c++) begin
         wb_valid = (c < 3);
         wb_addr  = 5'(10 + c);
         wb_data  = 32'(100 + c);
         @(negedge clk);
         if (rf_rw === 1'b0) wr_q.push_back(rf_addr);
         if (sw_ack === 1'b1) acks++;
         tick();
         if (acks > 0) sw_req = 1'b0;
      end
      chk("t6_writes", 32'(wr_q.size()), 32'd3);
      chk("t6_wr0", 32'(wr_q[0]), 32'd10);
      chk("t6_wr1", 32'(wr_q[1]), 32'd11);
      chk("t6_wr2", 32'(wr_q[2]), 32'd12);
      chk("t6_acks", 32'(acks), 32'd1);
      chk("t6_bank", 32'(cur_bank), 32'd0);
      idle_inputs();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
